// File: rtl/adc_cap_pkg.sv
// Shared types and default widths for the ADC capture gate.
// Imported by the gate FSM and its two-entry output buffer.
package adc_cap_pkg;

    localparam int DATA_W    = 128;
    localparam int CNT_W     = 32;
    localparam int SKIP_W    = 16;
    localparam int OVF_W     = 16;
    localparam int BUF_DEPTH = 2;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        SKIP,
        CAPTURE,
        DRAIN
    } cap_state_e;

endpackage

// File: rtl/adc_cap_gate_axis_buf2.sv
// Two-entry fully registered AXIS buffer carrying {tlast, tdata}.
// Slot 0 is always the head; a read shifts slot 1 forward.
module axis_buf2 #(
    parameter int W = 129
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         full,
    output logic         empty
);
    import adc_cap_pkg::*;

    logic [W-1:0] mem0_q;
    logic [W-1:0] mem1_q;
    logic [1:0]   cnt_q;
    logic         rd;

    assign out_valid = (cnt_q != 2'd0);
    assign empty     = (cnt_q == 2'd0);
    assign full      = (cnt_q == 2'(BUF_DEPTH));
    assign out_data  = mem0_q;
    assign rd        = rd_ready && out_valid;

    // A write while full without a read is dropped here; the
    // caller counts it as overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0_q <= '0;
            mem1_q <= '0;
            cnt_q  <= 2'd0;
        end else if (flush) begin
            cnt_q <= 2'd0;
        end else begin
            unique case (cnt_q)
                2'd0: begin
                    if (wr_en) begin
                        mem0_q <= wr_data;
                        cnt_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (wr_en && rd) begin
                        mem0_q <= wr_data;
                    end else if (wr_en) begin
                        mem1_q <= wr_data;
                        cnt_q  <= 2'd2;
                    end else if (rd) begin
                        cnt_q <= 2'd0;
                    end
                end
                2'd2: begin
                    if (rd) begin
                        mem0_q <= mem1_q;
                        if (wr_en) begin
                            mem1_q <= wr_data;
                        end else begin
                            cnt_q <= 2'd1;
                        end
                    end
                end
                default: cnt_q <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/adc_cap_gate.sv
// Per-channel ADC capture gate: arm, trigger, skip, then forward
// cap_size beats through a small buffer that absorbs backpressure.
module adc_cap_gate #(
    parameter int DATA_W = adc_cap_pkg::DATA_W,
    parameter int CNT_W  = adc_cap_pkg::CNT_W,
    parameter int SKIP_W = adc_cap_pkg::SKIP_W,
    parameter int OVF_W  = adc_cap_pkg::OVF_W
) (
    input  logic              rf_clk,
    input  logic              rf_rstb,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    input  logic              cfg_arm,
    input  logic              cfg_abort,
    input  logic [CNT_W-1:0]  cfg_cap_size,
    input  logic [SKIP_W-1:0] cfg_skip,
    input  logic              trig_en,
    input  logic              trig_in,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic [OVF_W-1:0]  ovf_cnt
);
    import adc_cap_pkg::*;

    cap_state_e        state_q, state_d;
    logic [CNT_W-1:0]  size_q, size_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [OVF_W-1:0]  ovf_q, ovf_d;
    logic              trig_en_q, trig_en_d;
    logic              trig_prev_q;
    logic              done_q, done_d;
    logic              ready_q;
    logic              wr_en, wr_last, flush;
    logic              buf_full, buf_empty, buf_rd;
    logic [DATA_W:0]   buf_out;

    axis_buf2 #(
        .W(DATA_W + 1)
    ) u_buf (
        .clk      (rf_clk),
        .rst_n    (rf_rstb),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_data  ({wr_last, s_axis_tdata}),
        .rd_ready (m_axis_tready),
        .out_data (buf_out),
        .out_valid(m_axis_tvalid),
        .full     (buf_full),
        .empty    (buf_empty)
    );

    assign m_axis_tdata  = buf_out[DATA_W-1:0];
    assign m_axis_tlast  = buf_out[DATA_W];
    assign buf_rd        = m_axis_tvalid && m_axis_tready;
    assign s_axis_tready = ready_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign beat_cnt      = beat_q;
    assign ovf_cnt       = ovf_q;

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        beat_d    = beat_q;
        skip_d    = skip_q;
        ovf_d     = ovf_q;
        trig_en_d = trig_en_q;
        done_d    = done_q;
        wr_en     = 1'b0;
        wr_last   = 1'b0;
        flush     = 1'b0;
        if (cfg_abort) begin
            state_d = IDLE;
            flush   = 1'b1;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cfg_arm && cfg_cap_size != '0) begin
                        size_d    = cfg_cap_size;
                        skip_d    = cfg_skip;
                        trig_en_d = trig_en;
                        beat_d    = '0;
                        ovf_d     = '0;
                        done_d    = 1'b0;
                        state_d   = ARMED;
                    end else if (cfg_arm) begin
                        done_d = 1'b1;
                    end
                end
                ARMED: begin
                    if (!trig_en_q || (trig_in && !trig_prev_q)) begin
                        state_d = SKIP;
                    end
                end
                SKIP: begin
                    if (skip_q == '0) begin
                        state_d = CAPTURE;
                    end else if (s_axis_tvalid) begin
                        skip_d = skip_q - SKIP_W'(1);
                        if (skip_q == SKIP_W'(1)) begin
                            state_d = CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (s_axis_tvalid && (!buf_full || buf_rd)) begin
                        wr_en  = 1'b1;
                        beat_d = beat_q + CNT_W'(1);
                        if (beat_d == size_q) begin
                            wr_last = 1'b1;
                            state_d = DRAIN;
                        end
                    end else if (s_axis_tvalid && ovf_q != '1) begin
                        ovf_d = ovf_q + OVF_W'(1);
                    end
                end
                DRAIN: begin
                    if (buf_rd && m_axis_tlast) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge rf_clk or negedge rf_rstb) begin
        if (!rf_rstb) begin
            state_q     <= IDLE;
            size_q      <= '0;
            beat_q      <= '0;
            skip_q      <= '0;
            ovf_q       <= '0;
            trig_en_q   <= 1'b0;
            trig_prev_q <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            beat_q      <= beat_d;
            skip_q      <= skip_d;
            ovf_q       <= ovf_d;
            trig_en_q   <= trig_en_d;
            trig_prev_q <= trig_in;
            done_q      <= done_d;
            ready_q     <= 1'b1;
        end
    end

    logic unused_ok;
    assign unused_ok = buf_empty;

endmodule

// File: tb/tb_adc_cap_gate.sv
// Randomized bench for adc_cap_gate against a queue-based
// behavioural model of the capture sequence.
module tb_adc_cap_gate;

    localparam int DW = 128;
    localparam int CW = 32;
    localparam int SW = 16;
    localparam int OW = 4;
    localparam int OVF_MAX = (1 << OW) - 1;

    logic          rf_clk = 1'b0;
    logic          rf_rstb = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic          cfg_arm = 1'b0;
    logic          cfg_abort = 1'b0;
    logic [CW-1:0] cfg_cap_size = '0;
    logic [SW-1:0] cfg_skip = '0;
    logic          trig_en = 1'b0;
    logic          trig_in = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] beat_cnt;
    logic [OW-1:0] ovf_cnt;

    adc_cap_gate #(
        .DATA_W(DW),
        .CNT_W (CW),
        .SKIP_W(SW),
        .OVF_W (OW)
    ) dut (
        .rf_clk       (rf_clk),
        .rf_rstb      (rf_rstb),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .cfg_arm      (cfg_arm),
        .cfg_abort    (cfg_abort),
        .cfg_cap_size (cfg_cap_size),
        .cfg_skip     (cfg_skip),
        .trig_en      (trig_en),
        .trig_in      (trig_in),
        .busy         (busy),
        .done         (done),
        .beat_cnt     (beat_cnt),
        .ovf_cnt      (ovf_cnt)
    );

    always #5 rf_clk = ~rf_clk;

    int n_run = 0;
    int n_fail = 0;

    // Model: ph 0 idle, 1 waiting trigger, 2 skipping, 3 capturing, 4 draining
    logic [DW:0]   mq[$];
    int            ph = 0;
    int            m_size = 0;
    int            m_skip = 0;
    int            m_beat = 0;
    int            m_ovf = 0;
    int            m_pops = 0;
    bit            m_trig_en = 0;
    bit            m_done = 0;
    bit            m_rdy = 0;
    bit            m_prev = 0;

    int            vpct = 100;
    int            rpct = 100;
    int            tpct = 0;
    bit            rand_trig = 0;
    logic [DW-1:0] din = '0;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [DW:0] head;
        int ph0;
        bit rd;
        bit got_last;
        rd = (mq.size() != 0) && m_axis_tready;
        ph0 = ph;
        got_last = 0;
        m_rdy = 1;
        if (cfg_abort) begin
            mq.delete();
            ph = 0;
            m_done = 0;
        end else begin
            if (rd) begin
                head = mq.pop_front();
                got_last = head[DW];
                m_pops++;
            end
            case (ph0)
                0: if (cfg_arm) begin
                    if (cfg_cap_size != 0) begin
                        m_size = int'(cfg_cap_size);
                        m_skip = int'(cfg_skip);
                        m_trig_en = trig_en;
                        m_beat = 0;
                        m_ovf = 0;
                        m_done = 0;
                        ph = 1;
                    end else begin
                        m_done = 1;
                    end
                end
                1: if (!m_trig_en || (trig_in && !m_prev)) ph = 2;
                2: begin
                    if (m_skip == 0) ph = 3;
                    else if (s_axis_tvalid) begin
                        m_skip--;
                        if (m_skip == 0) ph = 3;
                    end
                end
                3: if (s_axis_tvalid) begin
                    if (mq.size() < 2) begin
                        m_beat++;
                        mq.push_back({m_beat == m_size, s_axis_tdata});
                        if (m_beat == m_size) ph = 4;
                    end else if (m_ovf < OVF_MAX) begin
                        m_ovf++;
                    end
                end
                default: ;
            endcase
            if (got_last) begin
                m_done = 1;
                ph = 0;
            end
        end
        m_prev = trig_in;
    endtask

    task automatic check_all();
        logic [DW:0] head;
        chk("s_tready", DW'(s_axis_tready), DW'(m_rdy));
        chk("m_tvalid", DW'(m_axis_tvalid), DW'(mq.size() != 0));
        if (mq.size() != 0) begin
            head = mq[0];
            chk("m_tdata", m_axis_tdata, head[DW-1:0]);
            chk("m_tlast", DW'(m_axis_tlast), DW'(head[DW]));
        end
        chk("busy", DW'(busy), DW'(ph != 0));
        chk("done", DW'(done), DW'(m_done));
        chk("beat_cnt", DW'(beat_cnt), DW'(m_beat));
        chk("ovf_cnt", DW'(ovf_cnt), DW'(m_ovf));
    endtask

    // Called at a falling edge; drives one cycle of stimulus.
    task automatic cycle();
        s_axis_tvalid = ($urandom_range(99, 0) < vpct);
        s_axis_tdata = din;
        if (s_axis_tvalid) din = din + 1'b1;
        m_axis_tready = ($urandom_range(99, 0) < rpct);
        if (rand_trig && $urandom_range(99, 0) < tpct) trig_in = ~trig_in;
        @(posedge rf_clk);
        if (rf_rstb) model_step();
        @(negedge rf_clk);
        cfg_arm = 1'b0;
        cfg_abort = 1'b0;
        check_all();
    endtask

    task automatic arm(input int size, input int skip, input bit te);
        cfg_arm = 1'b1;
        cfg_cap_size = CW'(size);
        cfg_skip = SW'(skip);
        trig_en = te;
        cycle();
    endtask

    task automatic run_done(input int max);
        int n;
        n = 0;
        while ((ph != 0 || mq.size() != 0) && n < max) begin
            cycle();
            n++;
        end
        chk("finish_in_time", DW'(ph == 0 && mq.size() == 0), DW'(1));
    endtask

    initial begin
        @(negedge rf_clk);
        repeat (3) cycle();
        rf_rstb = 1'b1;
        repeat (2) cycle();

        din = DW'(16);
        arm(4, 0, 0);
        run_done(40);
        repeat (2) cycle();

        din = '0;
        arm(2, 3, 0);
        run_done(40);

        arm(8, 0, 0);
        repeat (4) cycle();
        rpct = 0;
        repeat (5) cycle();
        rpct = 100;
        run_done(60);

        trig_in = 1'b1;
        cycle();
        arm(3, 0, 1);
        repeat (6) cycle();
        trig_in = 1'b0;
        cycle();
        trig_in = 1'b1;
        run_done(40);
        trig_in = 1'b0;

        arm(8, 0, 0);
        m_pops = 0;
        for (int n = 0; n < 50 && m_pops < 2; n++) cycle();
        cfg_abort = 1'b1;
        cycle();
        arm(2, 0, 0);
        run_done(40);

        arm(0, 0, 0);
        repeat (3) cycle();
        arm(5, 1, 0);
        repeat (4) cycle();
        cfg_arm = 1'b1;
        cfg_cap_size = CW'(1);
        cycle();
        run_done(40);
        cfg_arm = 1'b1;
        cfg_abort = 1'b1;
        cfg_cap_size = CW'(4);
        cycle();
        repeat (3) cycle();

        rpct = 0;
        arm(30, 0, 0);
        repeat (25) cycle();
        rpct = 100;
        run_done(100);

        rand_trig = 1;
        tpct = 20;
        for (int it = 0; it < 60; it++) begin
            vpct = int'($urandom_range(100, 30));
            rpct = int'($urandom_range(100, 20));
            arm(int'($urandom_range(12, 1)), int'($urandom_range(5, 0)),
                bit'($urandom_range(1, 0)));
            for (int k = 0; k < int'($urandom_range(40, 5)); k++) begin
                if ($urandom_range(99, 0) < 2) cfg_abort = 1'b1;
                if ($urandom_range(99, 0) < 3) begin
                    cfg_arm = 1'b1;
                    cfg_cap_size = CW'($urandom_range(6, 0));
                    cfg_skip = SW'($urandom_range(3, 0));
                    trig_en = bit'($urandom_range(1, 0));
                end
                cycle();
            end
            run_done(500);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
